// File: rtl/instr_line_cache.sv
// Read-only direct-mapped instruction cache: zero-cycle hits, whole-line refill
// from the mem_ctrl host port on a miss.
module instr_line_cache #(
    parameter int LINES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  addr,
    input  logic         en,
    input  logic         inval,
    output logic         done,
    output logic [31:0]  data_out,
    output logic         stall,
    output logic         cache_hit,
    input  logic [511:0] DataIn_host,
    input  logic         rd_valid_host,
    input  logic         tx_done_host,
    output logic [511:0] DataOut_host,
    output logic [31:0]  AddrOut_host,
    output logic [1:0]   op_host,
    output logic [1:0]   state_dbg
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 26 - IDX_W;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    // Host handshake: while op_host=01 the read request on AddrOut_host is held
    // stable; the line is accepted in the single cycle rd_valid_host is high,
    // and the transaction ends in the cycle tx_done_host is high.
    state_t             state;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [511:0]       data_q [LINES];
    logic [TAG_W-1:0]   lat_tag;
    logic [IDX_W-1:0]   lat_idx;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [3:0]         word;
    logic               lookup_hit;
    logic               miss_start;
    logic               unused_bits;

    assign idx         = addr[6+IDX_W-1:6];
    assign tag         = addr[31:6+IDX_W];
    assign word        = addr[5:2];
    assign unused_bits = ^addr[1:0];

    assign lookup_hit = (state == S_IDLE) && en && valid_q[idx] && (tag_q[idx] == tag);
    assign miss_start = (state == S_IDLE) && en && !lookup_hit;

    // Combinational outputs are forced low while reset is held, even if en is high.
    assign done         = rst_n && lookup_hit;
    assign cache_hit    = rst_n && lookup_hit;
    assign stall        = rst_n && (miss_start || (state != S_IDLE));
    assign data_out     = data_q[idx][{word, 5'd0} +: 32];
    assign DataOut_host = '0;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            valid_q      <= '0;
            op_host      <= OP_IDLE;
            AddrOut_host <= '0;
            lat_tag      <= '0;
            lat_idx      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inval) valid_q <= '0;
                    if (miss_start) begin
                        lat_tag      <= tag;
                        lat_idx      <= idx;
                        AddrOut_host <= {tag, idx, 6'b0};
                        op_host      <= OP_READ;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (inval) valid_q <= '0;
                    if (rd_valid_host) begin
                        valid_q[lat_idx] <= 1'b1;
                        op_host          <= OP_IDLE;
                        state            <= tx_done_host ? S_IDLE : S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // The line filled in REQ belongs to this miss and survives an invalidate.
                    if (inval) begin
                        valid_q          <= '0;
                        valid_q[lat_idx] <= 1'b1;
                    end
                    if (tx_done_host) state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    op_host <= OP_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_REQ && rd_valid_host) begin
            data_q[lat_idx] <= DataIn_host;
            tag_q[lat_idx]  <= lat_tag;
        end
    end

endmodule

// File: doc/instr_line_cache.md
# instr_line_cache

Read-only, direct-mapped instruction cache between the fetch stage and the memory controller (mem_ctrl). Fetch presents a byte address each cycle. On a hit the 32-bit instruction is returned combinationally with `done` high. On a miss the block stalls fetch, reads the full 512-bit line over the host port of mem_ctrl, fills it, and then serves the word.

## Interface
Parameters:
- `LINES`, default 4: number of 64-byte lines; power of two, ≥2. `IDX_W = log2(LINES)`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in 32: fetch byte address (PC). `[1:0]` ignored, `[5:2]` word select, `[5+IDX_W:6]` index, `[31:6+IDX_W]` tag.
- `en` in 1: lookup request.
- `inval` in 1: invalidate all lines.
- `done` out 1: `data_out` valid this cycle.
- `data_out` out 32: instruction word.
- `stall` out 1: miss in progress; fetch holds PC.
- `cache_hit` out 1: `en` and hit this cycle.
- `DataIn_host` in 512: line data from mem_ctrl.
- `rd_valid_host` in 1: `DataIn_host` valid this cycle.
- `tx_done_host` in 1: mem_ctrl transaction complete.
- `DataOut_host` out 512: tied to 0 (read-only).
- `AddrOut_host` out 32: line-aligned request address (`[5:0]=0`).
- `op_host` out 2: 00 idle, 01 read, 10 write (never driven), 11 reserved.

## Operation
- Storage per line: valid bit, tag, 512-bit data. Word k of a line = `data[32k+31:32k]`.
- States:
  - IDLE: combinational lookup.
    - Hit = `en & valid[idx] & tag match`. On hit: `done=1`, `cache_hit=1`, `stall=0`.
    - On `en` and miss: `stall=1`, `done=0`, latch `{tag,idx}` of `addr`, go to REQ.
  - REQ: `op_host=01`, `AddrOut_host={latched tag,idx,6'b0}`, both held stable.
    - On `rd_valid_host`: write `DataIn_host` into the latched line, set valid, write tag.
    - If `tx_done_host` is also high that cycle, go to IDLE; otherwise go to WAIT_DONE.
  - WAIT_DONE: `op_host=00`; go to IDLE on `tx_done_host`.
- `stall=1` in REQ and WAIT_DONE regardless of `en`. `done=0` there.
- After return to IDLE, lookup is re-evaluated on the current `addr`. If fetch changed `addr` mid-miss, the latched line is still filled and the new address may miss again.
- `en=0` in IDLE: `done=0`, `stall=0`, no request.
- `inval`:
  - In IDLE: clears all valid bits at the clock edge; lookup in the same cycle still uses the pre-clear state.
  - In REQ/WAIT_DONE: clears all bits, but the in-flight fill still sets its own valid bit.
- `rd_valid_host` in IDLE/WAIT_DONE: ignored. A second `rd_valid_host` in REQ cannot occur.
- Conflict: a new line at the same index overwrites the old one (no victim).

## Timing
- Reset values: all valid=0, state IDLE, `op_host=00`, `AddrOut_host=0`, `DataOut_host=0`, `done=0`, `cache_hit=0`, `stall=0` (outputs held 0 while `rst_n=0`).
- Reset asserted mid-miss aborts the request (`op_host=00` immediately) and does not fill the line.
- Hit latency: 0 cycles (same-cycle `done`).
- Miss sequence:
  - Cycle M: miss detected, `stall=1`.
  - M+1: `op_host=01`.
  - Data accepted in the `rd_valid_host` cycle R.
  - `done` no earlier than the cycle after `tx_done_host`.
  - Minimum penalty 2 cycles when `rd_valid_host` and `tx_done_host` arrive at M+1.
- `AddrOut_host` and `op_host` are registered outputs.

## Test plan
- Cold miss at 0x00000008:
  - Required: `op_host=01`, `AddrOut_host=0x00000000` from M+1.
  - Drive a line with word k = 0x1000+k, `rd_valid_host` and `tx_done_host` 3 cycles later.
  - Expect `stall=1` until IDLE, then `done=1`, `data_out=0x00001002`.
- Hit sweep: addr 0x00..0x3C, one word per cycle after the fill → `done=1` every cycle, `data_out=0x1000..0x100F`, `op_host=00` throughout.
- Conflict (LINES=4): fill 0x000 then 0x100 (same index 0) → 0x000 misses again and a third read is issued at 0x00000000.
- Split handshake: `rd_valid_host` at cycle R, `tx_done_host` at R+2 → state WAIT_DONE for 2 cycles with `op_host=00`, `stall=1`, then a hit.
- Invalidate: fill line 0, pulse `inval` → next access to 0x04 misses. A concurrent in-flight fill remains valid afterwards.
- Reset mid-miss: assert `rst_n=0` during REQ → `op_host=00` and `stall=0` immediately. After release, the same address misses and re-requests.
